// File: rtl/waveform_gen.sv
// Strobe-driven sawtooth/triangle/square/DC generator, signed Q0.N_FRAC, one-cycle strobe latency.
// Optional macro WAVEFORM_GEN_SYNC_EN adds period_sync_o (period-wrap / mode-change pulse).
module waveform_gen #(
  parameter int N_FRAC = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [N_FRAC:0]   amplitude_i,
  input  logic signed [N_FRAC:0]   addend_i,
  input  logic        [1:0]        mode_i,
  input  logic                     next_data_strobe_i,
  output logic signed [N_FRAC:0]   data_o,
  output logic                     data_out_valid_strobe_o
`ifdef WAVEFORM_GEN_SYNC_EN
  ,
  output logic                     period_sync_o
`endif
);

  localparam int W  = N_FRAC + 1;
  localparam int SW = N_FRAC + 2;

  typedef enum logic [1:0] {MODE_SAW = 2'd0, MODE_TRI = 2'd1, MODE_SQR = 2'd2, MODE_DC = 2'd3} mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  function automatic logic signed [W-1:0] sat_nonneg(input logic signed [W-1:0] v);
    return v[W-1] ? '0 : v;
  endfunction

  mode_t               r_mode;
  dir_t                r_dir;
  logic signed [W-1:0] r_acc;

  logic signed [W-1:0]  w_amp;
  logic signed [W-1:0]  w_step;
  logic signed [W-1:0]  w_neg_amp;
  logic signed [SW-1:0] w_amp_x;
  logic signed [SW-1:0] w_neg_amp_x;
  logic signed [SW-1:0] w_sum_up;
  logic signed [SW-1:0] w_sum_dn;
  logic                 w_mode_chg;
  logic                 w_saw_wrap;
  logic                 w_tri_top;
  logic                 w_tri_bot;

  assign w_amp       = sat_nonneg(amplitude_i);
  assign w_step      = sat_nonneg(addend_i);
  assign w_amp_x     = SW'(w_amp);
  assign w_neg_amp_x = -w_amp_x;
  assign w_neg_amp   = w_neg_amp_x[W-1:0];
  // One extra bit of headroom: |acc|,|S| <= 2^N_FRAC-1 so these sums cannot wrap.
  assign w_sum_up    = SW'(r_acc) + SW'(w_step);
  assign w_sum_dn    = SW'(r_acc) - SW'(w_step);
  assign w_mode_chg  = (mode_t'(mode_i) != r_mode);
  assign w_saw_wrap  = (w_sum_up > w_amp_x);
  assign w_tri_top   = (w_sum_up >= w_amp_x);
  assign w_tri_bot   = (w_sum_dn <= w_neg_amp_x);

  mode_t               w_mode_nxt;
  dir_t                w_dir_nxt;
  logic signed [W-1:0] w_acc_nxt;
  logic signed [W-1:0] w_data_nxt;

  always_comb begin
    w_mode_nxt = r_mode;
    w_dir_nxt  = r_dir;
    w_acc_nxt  = r_acc;
    w_data_nxt = r_acc;
    if (w_mode_chg) begin
      w_mode_nxt = mode_t'(mode_i);
      w_dir_nxt  = DIR_UP;
      w_acc_nxt  = w_neg_amp;
      w_data_nxt = (mode_t'(mode_i) == MODE_DC) ? w_amp : w_neg_amp;
    end else begin
      unique case (r_mode)
        MODE_SAW, MODE_SQR: begin
          w_acc_nxt = w_saw_wrap ? w_neg_amp : w_sum_up[W-1:0];
          if (r_mode == MODE_SAW) w_data_nxt = w_acc_nxt;
          else                    w_data_nxt = w_acc_nxt[W-1] ? w_neg_amp : w_amp;
        end
        MODE_TRI: begin
          if (r_dir == DIR_UP) begin
            if (w_tri_top) begin
              w_acc_nxt = w_amp;
              w_dir_nxt = DIR_DOWN;
            end else begin
              w_acc_nxt = w_sum_up[W-1:0];
            end
          end else begin
            if (w_tri_bot) begin
              w_acc_nxt = w_neg_amp;
              w_dir_nxt = DIR_UP;
            end else begin
              w_acc_nxt = w_sum_dn[W-1:0];
            end
          end
          w_data_nxt = w_acc_nxt;
        end
        default: w_data_nxt = w_amp;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mode                  <= MODE_SAW;
      r_dir                   <= DIR_UP;
      r_acc                   <= '0;
      data_o                  <= '0;
      data_out_valid_strobe_o <= 1'b0;
    end else if (next_data_strobe_i) begin
      r_mode                  <= w_mode_nxt;
      r_dir                   <= w_dir_nxt;
      r_acc                   <= w_acc_nxt;
      data_o                  <= w_data_nxt;
      data_out_valid_strobe_o <= 1'b1;
    end else begin
      data_out_valid_strobe_o <= 1'b0;
    end
  end

`ifdef WAVEFORM_GEN_SYNC_EN
  logic w_sync_nxt;
  // Period boundary: saw/square wrap, triangle bottom turn, or entry to any non-DC mode.
  assign w_sync_nxt = w_mode_chg ? (mode_t'(mode_i) != MODE_DC) :
                      (((r_mode == MODE_SAW) || (r_mode == MODE_SQR)) && w_saw_wrap) ||
                      ((r_mode == MODE_TRI) && (r_dir == DIR_DOWN) && w_tri_bot);

  always_ff @(posedge clk_i) begin
    if (rst_i)                   period_sync_o <= 1'b0;
    else if (next_data_strobe_i) period_sync_o <= w_sync_nxt;
    else                         period_sync_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_waveform_gen.sv
// Scoreboard bench for waveform_gen: directed sequences with fixed expectations plus a
// randomized run checked against an integer reference model; a monitor pops and compares.
module tb_waveform_gen;
  localparam int N_FRAC = 7;

  logic                   clk = 1'b0;
  logic                   rst;
  logic signed [N_FRAC:0] amplitude;
  logic signed [N_FRAC:0] addend;
  logic        [1:0]      mode;
  logic                   strobe;
  logic signed [N_FRAC:0] data;
  logic                   valid;
`ifdef WAVEFORM_GEN_SYNC_EN
  logic                   sync;
`endif

  always #5 clk = ~clk;

  waveform_gen #(.N_FRAC(N_FRAC)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .amplitude_i             (amplitude),
    .addend_i                (addend),
    .mode_i                  (mode),
    .next_data_strobe_i      (strobe),
    .data_o                  (data),
    .data_out_valid_strobe_o (valid)
`ifdef WAVEFORM_GEN_SYNC_EN
    ,
    .period_sync_o           (sync)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int d; int sy; int at;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: generator state as plain integers.
  int m_acc  = 0;
  int m_mode = 0;
  bit m_up   = 1'b1;

  task automatic model_reset();
    m_acc = 0; m_mode = 0; m_up = 1'b1;
  endtask

  task automatic model_step(input int a_in, input int s_in, input int m, output int d, output int sy);
    int A, S;
    A  = (a_in < 0) ? 0 : a_in;
    S  = (s_in < 0) ? 0 : s_in;
    sy = 0;
    if (m != m_mode) begin
      m_mode = m; m_acc = -A; m_up = 1'b1;
      d  = (m == 3) ? A : -A;
      sy = (m != 3) ? 1 : 0;
    end else if (m == 0 || m == 2) begin
      if (m_acc + S > A) begin m_acc = -A; sy = 1; end
      else m_acc = m_acc + S;
      d = (m == 0) ? m_acc : ((m_acc >= 0) ? A : -A);
    end else if (m == 1) begin
      if (m_up) begin
        if (m_acc + S >= A) begin m_acc = A; m_up = 1'b0; end
        else m_acc = m_acc + S;
      end else begin
        if (m_acc - S <= -A) begin m_acc = -A; m_up = 1'b1; sy = 1; end
        else m_acc = m_acc - S;
      end
      d = m_acc;
    end else begin
      d = A;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Issue one strobe; expectation is the fixed value when use_want, otherwise the model's.
  task automatic do_strobe(input int a, input int s, input int m, input int want, input bit use_want);
    int d, sy;
    exp_t e;
    @(negedge clk);
    rst       = 1'b0;
    amplitude = a[N_FRAC:0];
    addend    = s[N_FRAC:0];
    mode      = m[1:0];
    strobe    = 1'b1;
    model_step(a, s, m, d, sy);
    e.d  = use_want ? want : d;
    e.sy = sy;
    e.at = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      strobe = 1'b0;
    end
  endtask

  task automatic do_reset(input int n, input bit with_strobe);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
      end
      rst    = 1'b1;
      strobe = with_strobe;
    end
    @(negedge clk);
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(valid), 0);
    rst    = 1'b0;
    strobe = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: got valid=1 data=%0d, expected no output (cycle %0d)", data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("data", int'(data), e.d);
        check("latency", cyc, e.at);
`ifdef WAVEFORM_GEN_SYNC_EN
        check("sync", int'(sync), e.sy);
`endif
      end
    end else if (q.size() > 0 && q[0].at < cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_valid: got valid=0, expected data=%0d at cycle %0d", e.d, e.at);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of run, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int saw_e[5] = '{30, 60, 90, -100, -70};
    int tri_e[12] = '{-100, -60, -20, 20, 60, 100, 60, 20, -20, -60, -100, -60};
    int sqr_e[6] = '{-100, -100, 100, 100, 100, -100};
    int ovf_e[5] = '{100, -127, -27, 73, -127};
    int a, s, m;

    rst = 1'b1; strobe = 1'b0; amplitude = '0; addend = '0; mode = '0;

    do_reset(3, 1'b1);
    foreach (saw_e[i]) do_strobe(100, 30, 0, saw_e[i], 1'b1);
    idle(2);

    do_reset(1, 1'b0);
    foreach (tri_e[i]) do_strobe(100, 40, 1, tri_e[i], 1'b1);
    idle(1);

    do_reset(1, 1'b0);
    for (int i = 0; i < 7; i++) do_strobe(100, 40, 1, tri_e[i], 1'b1);
    do_reset(1, 1'b1);
    do_strobe(100, 40, 0, 40, 1'b1);
    idle(1);

    do_reset(1, 1'b0);
    foreach (sqr_e[i]) do_strobe(100, 50, 2, sqr_e[i], 1'b1);
    idle(1);

    do_reset(1, 1'b0);
    foreach (ovf_e[i]) do_strobe(127, 100, 0, ovf_e[i], 1'b1);
    idle(1);

    do_reset(1, 1'b0);
    for (int i = 0; i < 4; i++) do_strobe(-5, 30, 0, 0, 1'b1);
    idle(1);

    for (int i = 0; i < 3; i++) do_strobe(50, 20, 3, 50, 1'b1);
    do_strobe(100, 30, 0, -100, 1'b1);
    do_strobe(100, 30, 0, -70, 1'b1);
    do_strobe(100, 0, 0, -70, 1'b1);
    do_strobe(100, 0, 0, -70, 1'b1);
    idle(2);

    a = 100; s = 17; m = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) m = $urandom_range(0, 3);
      if ($urandom_range(0, 20) == 0) a = $urandom_range(0, 255) - 128;
      if ($urandom_range(0, 10) == 0) s = $urandom_range(0, 170) - 40;
      do_strobe(a, s, m, 0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if ($urandom_range(0, 150) == 0) do_reset(1, $urandom_range(0, 1));
    end
    idle(4);

    check("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
